// File: rtl/axil_dna_reader.sv
// AXI-lite slave that drives an external DNA_PORT-style shift interface and exposes the ID as 32-bit words.
// Define AXIL_DNA_IRQ_EN to add the done_flag / irq_en / irq interrupt path.
module axil_dna_reader #(
   parameter int DNA_WIDTH  = 57,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH/8,
   parameter int CLK_DIV    = 4,
   parameter int AUTO_START = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic [2:0]            s_axil_awprot,
   input  logic                  s_axil_awvalid,
   output logic                  s_axil_awready,
   input  logic [DATA_WIDTH-1:0] s_axil_wdata,
   input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
   input  logic                  s_axil_wvalid,
   output logic                  s_axil_wready,
   output logic [1:0]            s_axil_bresp,
   output logic                  s_axil_bvalid,
   input  logic                  s_axil_bready,
   input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic [2:0]            s_axil_arprot,
   input  logic                  s_axil_arvalid,
   output logic                  s_axil_arready,
   output logic [DATA_WIDTH-1:0] s_axil_rdata,
   output logic [1:0]            s_axil_rresp,
   output logic                  s_axil_rvalid,
   input  logic                  s_axil_rready,
   output logic                  dna_clk,
   output logic                  dna_read,
   output logic                  dna_shift,
   output logic                  dna_din,
`ifdef AXIL_DNA_IRQ_EN
   output logic                  irq,
`endif
   input  logic                  dna_dout
);

   localparam int NW = (DNA_WIDTH + 31) / 32;
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = $clog2(DNA_WIDTH + 1);
   localparam int AW = ADDR_WIDTH - 2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [CW-1:0]         div_cnt_q, div_cnt_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DNA_WIDTH-1:0]  cap_q, cap_d;
   logic [DNA_WIDTH-1:0]  shadow_q, shadow_d;
   logic                  valid_q, valid_d;
   logic                  dna_clk_q, dna_clk_d;
   logic                  dna_read_q, dna_read_d;
   logic                  dna_shift_q, dna_shift_d;
   logic                  auto_q, auto_d;
   logic                  wr_ready_q, wr_ready_d;
   logic                  bvalid_q, bvalid_d;
   logic                  arready_q, arready_d;
   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;

   logic [AW-1:0]         wr_idx, rd_idx;
   logic                  wr_fire, rd_fire, ctrl_wr, busy, tick, rise, fall, start;
   logic [NW*32-1:0]      shadow_ext;
   logic [DATA_WIDTH-1:0] rd_word, status_word, ctrl_word;
   logic                  rd_err;
   logic                  unused_ok;

   assign wr_idx  = s_axil_awaddr[ADDR_WIDTH-1:2];
   assign rd_idx  = s_axil_araddr[ADDR_WIDTH-1:2];
   assign wr_fire = wr_ready_q & s_axil_awvalid & s_axil_wvalid;
   assign rd_fire = arready_q & s_axil_arvalid;
   assign ctrl_wr = wr_fire && (wr_idx == AW'(1));
   assign busy    = (state_q == S_LOAD) || (state_q == S_SHIFT);
   assign tick    = busy && (div_cnt_q == CW'(CLK_DIV - 1));
   assign rise    = tick & ~dna_clk_q;
   assign fall    = tick & dna_clk_q;
   assign start   = (state_q == S_IDLE) && (auto_q || (ctrl_wr && s_axil_wdata[0]));

   assign unused_ok = &{1'b0, s_axil_awprot, s_axil_arprot, s_axil_wstrb, s_axil_wdata,
                        s_axil_awaddr[1:0], s_axil_araddr[1:0]};

   // Shadow copy and dna_* strobes only change when dna_clk falls, so the primitive sees stable inputs.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path infers a latch.
      state_d     = state_q;
      div_cnt_d   = div_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      cap_d       = cap_q;
      shadow_d    = shadow_q;
      valid_d     = valid_q;
      dna_clk_d   = dna_clk_q;
      dna_read_d  = dna_read_q;
      dna_shift_d = dna_shift_q;
      auto_d      = auto_q;
      if (busy) begin
         div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
         if (tick) dna_clk_d = ~dna_clk_q;
      end
      case (state_q)
         S_IDLE: if (start) begin
            state_d    = S_LOAD;
            auto_d     = 1'b0;
            div_cnt_d  = '0;
            bit_cnt_d  = '0;
            cap_d      = '0;
            shadow_d   = '0;
            valid_d    = 1'b0;
            dna_clk_d  = 1'b0;
            dna_read_d = 1'b1;
         end
         S_LOAD: if (fall) begin
            state_d     = S_SHIFT;
            dna_read_d  = 1'b0;
            dna_shift_d = 1'b1;
         end
         S_SHIFT: begin
            if (rise) begin
               cap_d     = (cap_q << 1) | DNA_WIDTH'(dna_dout);
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
            if (fall && (bit_cnt_q == BW'(DNA_WIDTH))) begin
               state_d     = S_DONE;
               dna_shift_d = 1'b0;
            end
         end
         default: begin
            shadow_d = cap_q;
            valid_d  = 1'b1;
            state_d  = S_IDLE;
         end
      endcase
   end

`ifdef AXIL_DNA_IRQ_EN
   logic done_flag_q, done_flag_d, irq_en_q, irq_en_d, irq_q, irq_d;
   assign status_word = {{(DATA_WIDTH-3){1'b0}}, done_flag_q, busy, valid_q};
   assign ctrl_word   = {{(DATA_WIDTH-2){1'b0}}, irq_en_q, 1'b0};
   assign irq         = irq_q;

   // Set in DONE is applied last so it wins over a same-cycle W1C clear.
   always_comb begin
      irq_en_d    = irq_en_q;
      done_flag_d = done_flag_q;
      if (ctrl_wr) irq_en_d = s_axil_wdata[1];
      if (wr_fire && (wr_idx == AW'(0)) && s_axil_wdata[2]) done_flag_d = 1'b0;
      if (state_q == S_DONE) done_flag_d = 1'b1;
      irq_d = done_flag_d & irq_en_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done_flag_q <= 1'b0;
         irq_en_q    <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         done_flag_q <= done_flag_d;
         irq_en_q    <= irq_en_d;
         irq_q       <= irq_d;
      end
   end
`else
   assign status_word = {{(DATA_WIDTH-2){1'b0}}, busy, valid_q};
   assign ctrl_word   = '0;
`endif

   always_comb begin
      shadow_ext                 = '0;
      shadow_ext[DNA_WIDTH-1:0]  = shadow_q;
      rd_word = '0;
      rd_err  = 1'b1;
      if (rd_idx == AW'(0)) begin
         rd_word = status_word;
         rd_err  = 1'b0;
      end
      if (rd_idx == AW'(1)) begin
         rd_word = ctrl_word;
         rd_err  = 1'b0;
      end
      for (int k = 0; k < NW; k++) begin
         if (rd_idx == AW'(k + 2)) begin
            rd_word = shadow_ext[k*32 +: 32];
            rd_err  = 1'b0;
         end
      end
   end

   always_comb begin
      wr_ready_d = s_axil_awvalid & s_axil_wvalid & ~bvalid_q & ~wr_ready_q;
      bvalid_d   = bvalid_q & ~s_axil_bready;
      if (wr_fire) bvalid_d = 1'b1;
      arready_d  = s_axil_arvalid & ~rvalid_q & ~arready_q;
      rvalid_d   = rvalid_q & ~s_axil_rready;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      if (rd_fire) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_word;
         rresp_d  = rd_err ? 2'b10 : 2'b00;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         div_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         cap_q       <= '0;
         // NOTE: the ID shadow is a handful of flops rather than a RAM, so it is reset with the rest.
         shadow_q    <= '0;
         valid_q     <= 1'b0;
         dna_clk_q   <= 1'b0;
         dna_read_q  <= 1'b0;
         dna_shift_q <= 1'b0;
         auto_q      <= (AUTO_START != 0);
         wr_ready_q  <= 1'b0;
         bvalid_q    <= 1'b0;
         arready_q   <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         rresp_q     <= 2'b00;
      end else begin
         // NOTE: non-blocking updates so every flop samples the pre-edge value of the others.
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         cap_q       <= cap_d;
         shadow_q    <= shadow_d;
         valid_q     <= valid_d;
         dna_clk_q   <= dna_clk_d;
         dna_read_q  <= dna_read_d;
         dna_shift_q <= dna_shift_d;
         auto_q      <= auto_d;
         wr_ready_q  <= wr_ready_d;
         bvalid_q    <= bvalid_d;
         arready_q   <= arready_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         rresp_q     <= rresp_d;
      end
   end

   assign s_axil_awready = wr_ready_q;
   assign s_axil_wready  = wr_ready_q;
   assign s_axil_bresp   = 2'b00;
   assign s_axil_bvalid  = bvalid_q;
   assign s_axil_arready = arready_q;
   assign s_axil_rdata   = rdata_q;
   assign s_axil_rresp   = rresp_q;
   assign s_axil_rvalid  = rvalid_q;
   assign dna_clk        = dna_clk_q;
   assign dna_read       = dna_read_q;
   assign dna_shift      = dna_shift_q;
   assign dna_din        = 1'b0;

endmodule

// File: doc/axil_dna_reader.md
Name: axil_dna_reader

Overview:
- Parametrised successor to the fixed 7-series DNA register block: an AXI-lite slave that drives an external DNA_PORT-style shift interface, captures an ID of any width, and exposes it as N 32-bit words.
- Supports re-triggerable reads, a busy/valid status, and a programmable DNA clock divider.
- Sits on the control AXI-lite interconnect beside the other configuration slaves.
- The DNA primitive is instantiated outside the block, so the block simulates without vendor models.

Parameters:
DNA_WIDTH, 57, ID bit count (57 for 7-series, 96 for UltraScale); range 1..256.
DATA_WIDTH, 32, AXI-lite data width; only 32 is supported.
ADDR_WIDTH, 32, AXI-lite address width.
STRB_WIDTH, DATA_WIDTH/8, write strobe width.
CLK_DIV, 4, clk cycles per dna_clk half-period; must be at least 1.
AUTO_START, 1, when 1, a read starts automatically after reset.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous active-high reset.
s_axil_awaddr/awprot/awvalid/awready  AXI-lite write address (awprot ignored).
s_axil_wdata/wstrb/wvalid/wready  AXI-lite write data (wstrb ignored).
s_axil_bresp/bvalid/bready  AXI-lite write response.
s_axil_araddr/arprot/arvalid/arready  AXI-lite read address (arprot ignored).
s_axil_rdata/rresp/rvalid/rready  AXI-lite read data.
dna_clk  out  1  registered clock to the DNA primitive.
dna_read  out  1  load strobe to the primitive.
dna_shift  out  1  shift enable to the primitive.
dna_din  out  1  serial input to the primitive; tied to 0.
dna_dout  in  1  serial output from the primitive.

Behaviour:
Reset:
- All AXI ready/valid outputs, bresp, rresp, rdata, dna_clk, dna_read and dna_shift go to 0.
- DNA shadow registers go to 0; valid=0; FSM goes to IDLE.
- Reset asserted mid-operation aborts immediately, with no partial value kept.

Register map (word-aligned; address bits [1:0] ignored):
- 0x00 STATUS (RO): bit0 valid, bit1 busy.
- 0x04 CTRL (WO): writing bit0=1 starts a read.
- 0x08 + 4k DNA word k, for k = 0..NW-1, where NW = ceil(DNA_WIDTH/32).
  - Word 0 holds ID bits [31:0].
  - Unused upper bits of the last word read as 0.
- Reads of unmapped addresses return rdata=0, rresp=2'b10 (SLVERR).
- Writes to unmapped or read-only addresses are ignored with bresp=2'b00.

Write channel:
- awready and wready pulse together for one cycle when awvalid & wvalid & !bvalid.
- bvalid asserts the next cycle and holds until bready.
- No further write is accepted while bvalid=1.

Read channel:
- arready pulses for one cycle when arvalid & !rvalid.
- rvalid/rdata/rresp are registered and valid the next cycle; they hold until rready.

Simultaneous read and write in the same cycle are both accepted; the two channels are independent.

dna_clk generation:
- A half-period counter toggles dna_clk every CLK_DIV cycles while busy; dna_clk is held 0 in IDLE and DONE.
- All dna_* outputs change only on clk cycles where dna_clk transitions 1->0.

FSM:
- IDLE -> LOAD on a start request: CTRL write of bit0=1, or the first cycle after reset when AUTO_START=1. On entry: busy=1, valid=0, shadow registers cleared.
- LOAD: dna_read=1 for one full dna_clk period (one rising edge), then -> SHIFT.
- SHIFT: dna_shift=1. In the clk cycle that makes each dna_clk rising edge, dna_dout is shifted into the capture register (shift left, new bit at LSB), so the first-captured bit ends as ID bit DNA_WIDTH-1. After DNA_WIDTH captures -> DONE.
- DONE: for one cycle, copy the capture register to the shadow registers, set valid=1, busy=0, dna_shift=0 -> IDLE.
- A start request while busy is ignored, with bresp still OKAY.

Latency: start to valid = 2*CLK_DIV*(DNA_WIDTH+1) + 2 clk cycles, ±1.

Optional Feature:
Macro: AXIL_DNA_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit).
  - Adds STATUS bit2 done_flag: set in DONE; cleared by writing 1 to bit2 of 0x00 (W1C).
  - Adds CTRL bit1 irq_en, readable at 0x04 bit1.
  - irq = done_flag & irq_en, registered; reset to 0.
  - A set in DONE and a W1C clear in the same cycle resolve to set.
- Undefined: no irq port, STATUS bit2 reads 0, CTRL bit1 is ignored and 0x04 reads return 0.

Test Plan:
1. Reset release, DNA_WIDTH=57, CLK_DIV=4, DNA model preloaded with 57'h0123456789ABCDE and AUTO_START=1; poll STATUS -> 0x2 while busy, then 0x1. Word 0 (0x08) reads 0x789ABCDE, word 1 (0x0C) reads 0x00123456. Valid rises at about 466 clk cycles after reset.
2. Change the model value to 57'h1FFFFFFFFFFFFFF and write CTRL=0x1 -> STATUS reads 0x2 with both words 0 during the read. Afterwards, word 0 reads 0xFFFFFFFF and word 1 reads 0x01FFFFFF.
3. Write CTRL=0x1 twice, the second while busy -> exactly 58 dna_clk rising edges are counted; both B responses are OKAY.
4. Read address 0x40 -> rresp=2'b10, rdata=0. Hold rready low for 5 cycles -> rvalid and rdata stay stable, and no new arready occurs.
5. Assert rst for 1 cycle after 20 shift edges -> all outputs return to their reset values the next cycle. The restart completes with the correct value and without the partial one.
6. With AXIL_DNA_IRQ_EN and DNA_WIDTH=96 (3 words): set irq_en, start a read -> irq rises after DONE. Write 0x4 to 0x00 -> irq falls the next cycle; word 2 matches ID bits [95:64].
